// File: rtl/mem_bus_unit.sv
// Load/store bus unit: decodes access size and sign, drives a big-endian byte-lane
// bus with an ack timeout, reports address/bus errors and tracks the LL/SC link bit.
module mem_bus_unit #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic [3:0]            op,
   input  logic [ADDR_W-1:0]     addr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic                  flush,
   input  logic                  ll_clr,
   output logic                  bus_req,
   output logic                  bus_we,
   output logic [ADDR_W-1:0]     bus_addr,
   output logic [DATA_W/8-1:0]   bus_sel,
   output logic [DATA_W-1:0]     bus_wdata,
   input  logic                  bus_ack,
   input  logic [DATA_W-1:0]     bus_rdata,
   output logic                  wb_valid,
   output logic [DATA_W-1:0]     wb_data,
   output logic                  stall_req,
   output logic                  llbit,
   output logic                  exc_adel,
   output logic                  exc_ades,
   output logic                  bus_err,
   output logic [ADDR_W-1:0]     bad_vaddr
);
   localparam int unsigned NB  = DATA_W / 8;
   localparam int unsigned OB  = $clog2(NB);
   localparam logic [8:0]  TMO = 9'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;
   state_t state, state_nx;

   logic              is_store, is_ll, is_sc, is_signed, reserved, misal, sc_fail, go_bus;
   logic [1:0]        eff_sz;
   int unsigned       nbytes, lane_lo;
   logic [NB-1:0]     sel_nx;
   logic [DATA_W-1:0] wrep;

   logic [OB-1:0]     lane_q;
   logic [1:0]        sz_q;
   logic              signed_q, store_q, ll_q, sc_q;
   logic [7:0]        cnt;
   logic              cnt_hit, drop_q;
   logic [DATA_W-1:0] res_data;
   logic              res_adel, res_ades, res_err, res_ll, res_sc_ok;
   logic [ADDR_W-1:0] res_vaddr;
   logic [DATA_W-1:0] shifted, ld_mask, ld_top, ld_data;

   // Request decode: SC is always a word access; LL/SC class only defines sizes 10/11.
   always_comb begin
      is_store  = 1'b0;
      is_ll     = 1'b0;
      is_sc     = 1'b0;
      is_signed = 1'b0;
      reserved  = 1'b0;
      case (op[3:2])
         2'b00:   is_signed = 1'b1;
         2'b01:   is_signed = 1'b0;
         2'b10:   is_store  = 1'b1;
         default: begin
            if (op[1:0] == 2'b10) begin
               is_ll = 1'b1;
            end else if (op[1:0] == 2'b11) begin
               is_sc    = 1'b1;
               is_store = 1'b1;
            end else begin
               reserved = 1'b1;
            end
         end
      endcase
      if ((op[3:2] != 2'b11) && (op[1:0] == 2'b11) && (DATA_W != 64))
         reserved = 1'b1;
      eff_sz  = is_sc ? 2'd2 : op[1:0];
      nbytes  = 32'd1 << eff_sz;
      lane_lo = NB - 32'(addr[OB-1:0]) - nbytes;
      misal   = |(addr[2:0] & 3'(nbytes - 32'd1));
      sc_fail = is_sc & ~llbit;
      go_bus  = ~reserved & ~misal & ~sc_fail;
      sel_nx  = NB'(((32'd1 << nbytes) - 32'd1) << lane_lo);
      wrep    = '0;
      for (int unsigned k = 0; k < NB; k++)
         wrep[8*k +: 8] = wdata[8*(k & (nbytes - 32'd1)) +: 8];
   end

   // Load alignment: drop lanes below the access, then mask and extend from its top bit.
   always_comb begin
      shifted = bus_rdata >> {lane_q, 3'b000};
      ld_mask = ~({DATA_W{1'b1}} << (8 << sz_q));
      ld_top  = ld_mask & ~(ld_mask >> 1);
      ld_data = shifted & ld_mask;
      if (signed_q && |(shifted & ld_top))
         ld_data = ld_data | ~ld_mask;
   end

   assign cnt_hit = (({1'b0, cnt} + 9'd1) == TMO);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (req_valid && !flush) state_nx = go_bus ? BUS : DONE;
         BUS:     if (bus_ack || cnt_hit) state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign wb_valid  = (state == DONE) & ~drop_q & ~flush;
   assign stall_req = req_valid & ~wb_valid;
   assign wb_data   = wb_valid ? res_data  : '0;
   assign exc_adel  = wb_valid & res_adel;
   assign exc_ades  = wb_valid & res_ades;
   assign bus_err   = wb_valid & res_err;
   assign bad_vaddr = wb_valid ? res_vaddr : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_addr  <= '0;
         bus_sel   <= '0;
         bus_wdata <= '0;
         lane_q    <= '0;
         sz_q      <= '0;
         signed_q  <= 1'b0;
         store_q   <= 1'b0;
         ll_q      <= 1'b0;
         sc_q      <= 1'b0;
         cnt       <= '0;
         drop_q    <= 1'b0;
         res_data  <= '0;
         res_adel  <= 1'b0;
         res_ades  <= 1'b0;
         res_err   <= 1'b0;
         res_ll    <= 1'b0;
         res_sc_ok <= 1'b0;
         res_vaddr <= '0;
         llbit     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cnt    <= '0;
               drop_q <= 1'b0;
               if (req_valid && !flush) begin
                  res_data  <= '0;
                  res_err   <= 1'b0;
                  res_ll    <= 1'b0;
                  res_sc_ok <= 1'b0;
                  res_adel  <= ~reserved & misal & ~is_store;
                  res_ades  <= ~reserved & misal & is_store;
                  res_vaddr <= (~reserved & misal) ? addr : '0;
                  if (go_bus) begin
                     bus_req   <= 1'b1;
                     bus_we    <= is_store;
                     bus_addr  <= {addr[ADDR_W-1:OB], {OB{1'b0}}};
                     bus_sel   <= sel_nx;
                     bus_wdata <= is_store ? wrep : '0;
                     lane_q    <= OB'(lane_lo);
                     sz_q      <= eff_sz;
                     signed_q  <= is_signed;
                     store_q   <= is_store;
                     ll_q      <= is_ll;
                     sc_q      <= is_sc;
                  end
               end
            end
            BUS: begin
               if (flush) drop_q <= 1'b1;
               if (bus_ack || cnt_hit) begin
                  bus_req   <= 1'b0;
                  bus_we    <= 1'b0;
                  bus_addr  <= '0;
                  bus_sel   <= '0;
                  bus_wdata <= '0;
               end
               if (bus_ack) begin
                  res_data  <= store_q ? DATA_W'(sc_q) : ld_data;
                  res_ll    <= ll_q;
                  res_sc_ok <= sc_q;
               end else if (cnt_hit) begin
                  res_err <= 1'b1;
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            default: ;
         endcase
         // Link bit only moves on a completion that is actually written back.
         if (ll_clr)                   llbit <= 1'b0;
         else if (wb_valid && res_ll)  llbit <= 1'b1;
         else if (wb_valid && res_sc_ok) llbit <= 1'b0;
      end
   end
endmodule
